alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl_if.sv | 31 +++
 rtl/alu_serial_ctrl.sv | 104 ++++++++++
 tb/tb_alu_serial_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_if.sv
// alu_serial_ctrl_if
//   Command/result bundle for the bit-serial ALU controller.
//   Parameter WIDTH : operand/result width in bits.
//   cmd_valid/cmd_ready : command handshake; cmd_op, cmd_a and cmd_b carry the command.
//   res_valid/res_ready : result handshake; res_data, res_carry, res_zero and res_ovf carry the result.
//   master : the command issuer and result consumer. slave : the controller.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_zero;
    logic             res_ovf;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero, res_ovf
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero, res_ovf
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
//   Bit-serial ALU controller. It latches a command and steps an external 1-bit
//   ALU slice over the operands, LSB first, for WIDTH cycles. It then holds the
//   result and its flags until the consumer accepts them.
//   clk, reset     : single clock; synchronous active-high reset.
//   bus (slave)    : command and result handshakes (see alu_serial_ctrl_if).
//   slice_a/b/cin/s: operand bits, carry-in and op select driven to the slice.
//   slice_out/cout : slice result bit and carry-out (combinational in the slice).
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    alu_serial_ctrl_if.slave    bus,
    output logic                slice_a,
    output logic                slice_b,
    output logic                slice_cin,
    output logic [2:0]          slice_s,
    input  logic                slice_out,
    input  logic                slice_cout
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;   // carry into the current bit; holds the final carry in DONE
    logic             cmsb_q;    // carry into the MSB, used for signed overflow

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q    <= bus.cmd_op;
                        a_q     <= bus.cmd_a;
                        b_q     <= bus.cmd_b;
                        idx     <= '0;
                        // The slice inverts B for SUB; only the +1 comes from here.
                        carry_q <= (bus.cmd_op == 3'b001);
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx] <= slice_out;
                    carry_q       <= slice_cout;
                    if (idx == LAST) begin
                        cmsb_q <= carry_q;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic run;
    logic done;
    logic arith;

    always_comb begin
        run   = (state == RUN);
        done  = (state == DONE);
        arith = (op_q[2:1] == 2'b00);

        bus.cmd_ready = (state == IDLE);
        bus.res_valid = done;
        // Results are only presented in DONE, so a command interrupted by reset never shows a partial word.
        bus.res_data  = done ? result_q : '0;
        bus.res_zero  = done && (result_q == '0);
        bus.res_carry = done && arith && carry_q;
        bus.res_ovf   = done && arith && (cmsb_q ^ carry_q);

        slice_a   = run && a_q[idx];
        slice_b   = run && b_q[idx];
        slice_cin = run && carry_q;
        slice_s   = run ? op_q : 3'b000;
    end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         carry;
        logic         zero;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    logic slice_a, slice_b, slice_cin, slice_out, slice_cout;
    logic [2:0] slice_s;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int prev_pop = -1;
    bit bb_mode  = 1'b0;
    res_t sb[$];
    res_t mon_e;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_s    (slice_s),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 1-bit slice
    always_comb begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_s)
            3'b000: {slice_cout, slice_out} = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
            3'b001: {slice_cout, slice_out} = {1'b0, slice_a} + {1'b0, ~slice_b} + {1'b0, slice_cin};
            3'b010, 3'b011: slice_out = slice_a ^ slice_b;
            3'b100: slice_out = slice_a & slice_b;
            3'b101: slice_out = ~(slice_a & slice_b);
            3'b110: slice_out = ~(slice_a | slice_b);
            default: slice_out = slice_a | slice_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t exp_of(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        logic [W:0] s;
        r = '0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r.data = s[W-1:0];
                r.carry = s[W];
                r.ovf = (a[W-1] == b[W-1]) && (r.data[W-1] != a[W-1]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 1'b1;
                r.data = s[W-1:0];
                r.carry = s[W];
                r.ovf = (a[W-1] != b[W-1]) && (r.data[W-1] != a[W-1]);
            end
            3'b010, 3'b011: r.data = a ^ b;
            3'b100: r.data = a & b;
            3'b101: r.data = ~(a & b);
            3'b110: r.data = ~(a | b);
            default: r.data = a | b;
        endcase
        r.zero = (r.data == '0);
        return r;
    endfunction

    // Result monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", 32'(bus.res_data), 32'(mon_e.data));
                check("res_carry", 32'(bus.res_carry), 32'(mon_e.carry));
                check("res_zero", 32'(bus.res_zero), 32'(mon_e.zero));
                check("res_ovf", 32'(bus.res_ovf), 32'(mon_e.ovf));
                if (bb_mode) begin
                    if (prev_pop >= 0) check("period", 32'(cyc - prev_pop), W + 2);
                    prev_pop = cyc;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit push, input res_t e, output int waited);
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_valid = 1'b1;
        waited = 0;
        while (waited < 100) begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            waited++;
        end
        if (waited >= 100) begin
            check("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb.push_back(e);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int cnt;
        res_t e;
        logic [W-1:0] ra, rb;

        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_flags", 32'({bus.res_carry, bus.res_zero, bus.res_ovf}), 0);
        check("rst_slice", 32'({slice_a, slice_b, slice_cin, slice_s}), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ADD FF+01 with latency measurement (accept cycle counts as cycle 0)
        do_cmd(3'b000, 8'hFF, 8'h01, 1'b1, '{data: 8'h00, carry: 1'b1, zero: 1'b1, ovf: 1'b0}, w);
        cnt = 0;
        while (cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (bus.res_valid) break;
        end
        check("latency", cnt, W + 1);
        @(posedge clk);
        #1;
        drain();

        // SUB 80-01: first RUN cycle presents raw B bit and carry-in 1
        do_cmd(3'b001, 8'h80, 8'h01, 1'b1, '{data: 8'h7F, carry: 1'b1, zero: 1'b0, ovf: 1'b1}, w);
        @(negedge clk);
        check("sub_cin", 32'(slice_cin), 1);
        check("sub_s", 32'(slice_s), 32'(3'b001));
        check("sub_a0", 32'(slice_a), 0);
        check("sub_b0_raw", 32'(slice_b), 1);
        check("run_cmd_ready", 32'(bus.cmd_ready), 0);
        @(posedge clk);
        #1;
        drain();
        @(negedge clk);
        check("idle_slice", 32'({slice_a, slice_b, slice_cin, slice_s}), 0);
        @(posedge clk);
        #1;

        // NOR 0F,F0
        do_cmd(3'b110, 8'h0F, 8'hF0, 1'b1, '{data: 8'h00, carry: 1'b0, zero: 1'b1, ovf: 1'b0}, w);
        drain();

        // AND F0,3C held in DONE while inputs toggle
        bus.res_ready = 1'b0;
        do_cmd(3'b100, 8'hF0, 8'h3C, 1'b1, '{data: 8'h30, carry: 1'b0, zero: 1'b0, ovf: 1'b0}, w);
        cnt = 0;
        while (cnt < 40 && !bus.res_valid) begin
            @(negedge clk);
            cnt++;
        end
        check("stall_reached_done", 32'(bus.res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b1;
            bus.cmd_op = 3'($urandom);
            bus.cmd_a = W'($urandom);
            bus.cmd_b = W'($urandom);
            @(negedge clk);
            check("stall_data", 32'(bus.res_data), 32'h30);
            check("stall_flags", 32'({bus.res_valid, bus.res_carry, bus.res_zero, bus.res_ovf}), 32'b1000);
            check("stall_cmd_ready", 32'(bus.cmd_ready), 0);
            check("stall_slice", 32'({slice_a, slice_b, slice_cin, slice_s}), 0);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        do_cmd(3'b010, 8'hAA, 8'h55, 1'b1, '{data: 8'hFF, carry: 1'b0, zero: 1'b0, ovf: 1'b0}, w);
        check("accept_after_done", w, 0);
        drain();

        // Reset in the 4th RUN cycle of ADD 12+34; nothing is expected from it
        do_cmd(3'b000, 8'h12, 8'h34, 1'b0, '0, w);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrun_rst_ready", 32'(bus.cmd_ready), 1);
        check("midrun_rst_valid", 32'(bus.res_valid), 0);
        check("midrun_rst_slice", 32'({slice_a, slice_b, slice_cin, slice_s}), 0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("no_partial_valid", 32'(bus.res_valid), 0);
        end
        @(posedge clk);
        #1;
        do_cmd(3'b000, 8'h01, 8'h01, 1'b1, '{data: 8'h02, carry: 1'b0, zero: 1'b0, ovf: 1'b0}, w);
        drain();

        // Back-to-back random commands covering every op, res_ready tied high
        bb_mode = 1'b1;
        prev_pop = -1;
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i == 8) begin ra = 8'h7F; rb = 8'h01; end
            if (i == 9) begin ra = 8'h00; rb = 8'h00; end
            e = exp_of(3'(i), ra, rb);
            do_cmd(3'(i), ra, rb, 1'b1, e, w);
        end
        drain();
        bb_mode = 1'b0;
        check("bb_pops_seen", 32'(prev_pop >= 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
